// File: rtl/regfile_sequencer.sv
// regfile_sequencer: drives the regfile command bus through the command
// sequence for one register-level operation. ALU operations use a
// mid-sequence ALU handshake.

package regfile_pkg;
  localparam int unsigned INDEX_WIDTH = 3;

  localparam logic [3:0] COM_NOP      = 4'd0;
  localparam logic [3:0] COM_READA    = 4'd1;
  localparam logic [3:0] COM_READB    = 4'd2;
  localparam logic [3:0] COM_LATCHC   = 4'd3;
  localparam logic [3:0] COM_LATCHSEL = 4'd4;
  localparam logic [3:0] COM_READSP   = 4'd5;
  localparam logic [3:0] COM_READF    = 4'd6;
  localparam logic [3:0] COM_READRV   = 4'd7;
  localparam logic [3:0] COM_LATCHSP  = 4'd8;
  localparam logic [3:0] COM_LATCHF   = 4'd9;
  localparam logic [3:0] COM_LATCHRV  = 4'd10;
endpackage

module regfile_sequencer #(
  parameter int unsigned ALU_TIMEOUT = 16,
  parameter int unsigned INDEX_WIDTH = regfile_pkg::INDEX_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_req_valid,
  output logic                   o_req_ready,
  input  logic [2:0]             i_req_kind,
  input  logic [INDEX_WIDTH-1:0] i_req_a,
  input  logic [INDEX_WIDTH-1:0] i_req_b,
  input  logic [INDEX_WIDTH-1:0] i_req_c,
  output logic [3:0]             o_com,
  output logic [INDEX_WIDTH-1:0] o_sel,
  output logic                   o_alu_start,
  input  logic                   i_alu_done,
  output logic                   o_done,
  output logic                   o_err,
  input  logic                   i_err_clr
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_SEL_A    = 4'd1;
  localparam logic [3:0] S_RD_A     = 4'd2;
  localparam logic [3:0] S_SEL_B    = 4'd3;
  localparam logic [3:0] S_RD_B     = 4'd4;
  localparam logic [3:0] S_ALU_WAIT = 4'd5;
  localparam logic [3:0] S_SEL_C    = 4'd6;
  localparam logic [3:0] S_LAT_C    = 4'd7;
  localparam logic [3:0] S_SPECIAL  = 4'd8;

  localparam int unsigned CNT_W = (ALU_TIMEOUT == 0) ? 1 : $clog2(ALU_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ALU_TIMEOUT);

  logic [3:0]             r_state;
  logic [INDEX_WIDTH-1:0] r_a;
  logic [INDEX_WIDTH-1:0] r_b;
  logic [INDEX_WIDTH-1:0] r_c;
  logic [CNT_W-1:0]       r_cnt;
  logic [3:0]             r_com;
  logic [INDEX_WIDTH-1:0] r_sel;
  logic                   r_alu_start;
  logic                   r_done;
  logic                   r_err;
  logic                   r_ready;

  logic [3:0]             w_state_nxt;
  logic [3:0]             w_com_nxt;
  logic [INDEX_WIDTH-1:0] w_sel_nxt;
  logic                   w_start_nxt;
  logic                   w_done_nxt;
  logic                   w_err_set;
  logic                   w_accept;
  logic                   w_timeout;

  assign w_accept    = i_req_valid && r_ready && (r_state == S_IDLE);
  assign o_req_ready = r_ready;
  assign o_com       = r_com;
  assign o_sel       = r_sel;
  assign o_alu_start = r_alu_start;
  assign o_done      = r_done;
  assign o_err       = r_err;

  // Next-state selection plus decode of the registered command outputs.
  // The abort decision is taken one wait cycle early so that o_done/o_err
  // land together in the registered cycle that ends the timeout window.
  always_comb begin
    w_state_nxt = r_state;
    w_start_nxt = 1'b0;
    w_done_nxt  = 1'b0;
    w_err_set   = 1'b0;
    w_com_nxt   = regfile_pkg::COM_NOP;
    w_sel_nxt   = '0;
    w_timeout   = (ALU_TIMEOUT != 0) && ((32'(r_cnt) + 32'd2) >= ALU_TIMEOUT);

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (i_req_kind == 3'd0) begin
            w_state_nxt = S_SEL_A;
          end else if (i_req_kind == 3'd7) begin
            w_done_nxt = 1'b1;
            w_err_set  = 1'b1;
          end else begin
            w_state_nxt = S_SPECIAL;
            w_done_nxt  = 1'b1;
          end
        end
      end
      S_SEL_A:  w_state_nxt = S_RD_A;
      S_RD_A: begin
        w_state_nxt = (r_b == r_a) ? S_RD_B : S_SEL_B;
        w_start_nxt = (r_b == r_a);
      end
      S_SEL_B: begin
        w_state_nxt = S_RD_B;
        w_start_nxt = 1'b1;
      end
      S_RD_B: begin
        if (ALU_TIMEOUT == 1) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
          w_err_set   = 1'b1;
        end else begin
          w_state_nxt = S_ALU_WAIT;
        end
      end
      S_ALU_WAIT: begin
        if (i_alu_done) begin
          w_state_nxt = (r_c == r_b) ? S_LAT_C : S_SEL_C;
          w_done_nxt  = (r_c == r_b);
        end else if (w_timeout) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
          w_err_set   = 1'b1;
        end
      end
      S_SEL_C: begin
        w_state_nxt = S_LAT_C;
        w_done_nxt  = 1'b1;
      end
      S_LAT_C:   w_state_nxt = S_IDLE;
      S_SPECIAL: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase

    case (w_state_nxt)
      S_SEL_A: begin
        w_com_nxt = regfile_pkg::COM_LATCHSEL;
        w_sel_nxt = i_req_a;
      end
      S_RD_A: w_com_nxt = regfile_pkg::COM_READA;
      S_SEL_B: begin
        w_com_nxt = regfile_pkg::COM_LATCHSEL;
        w_sel_nxt = r_b;
      end
      S_RD_B: w_com_nxt = regfile_pkg::COM_READB;
      S_SEL_C: begin
        w_com_nxt = regfile_pkg::COM_LATCHSEL;
        w_sel_nxt = r_c;
      end
      S_LAT_C: w_com_nxt = regfile_pkg::COM_LATCHC;
      S_SPECIAL: begin
        case (i_req_kind)
          3'd1:    w_com_nxt = regfile_pkg::COM_READSP;
          3'd2:    w_com_nxt = regfile_pkg::COM_READF;
          3'd3:    w_com_nxt = regfile_pkg::COM_READRV;
          3'd4:    w_com_nxt = regfile_pkg::COM_LATCHSP;
          3'd5:    w_com_nxt = regfile_pkg::COM_LATCHF;
          3'd6:    w_com_nxt = regfile_pkg::COM_LATCHRV;
          default: w_com_nxt = regfile_pkg::COM_NOP;
        endcase
      end
      default: w_com_nxt = regfile_pkg::COM_NOP;
    endcase
  end

  // State, registered outputs and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_com       <= regfile_pkg::COM_NOP;
      r_sel       <= '0;
      r_alu_start <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_ready     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_com       <= w_com_nxt;
      r_sel       <= w_sel_nxt;
      r_alu_start <= w_start_nxt;
      r_done      <= w_done_nxt;
      r_ready     <= (w_state_nxt == S_IDLE);
      if (w_err_set) begin
        r_err <= 1'b1;
      end else if (i_err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

  // Request operand capture on acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a <= '0;
      r_b <= '0;
      r_c <= '0;
    end else if (w_accept) begin
      r_a <= i_req_a;
      r_b <= i_req_b;
      r_c <= i_req_c;
    end
  end

  // ALU wait counter: cleared when entering ALU_WAIT, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_state == S_RD_B) begin
      r_cnt <= '0;
    end else if ((r_state == S_ALU_WAIT) && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Self-checking bench for regfile_sequencer with a reference model that
// derives the per-cycle command trace from operation-level rules.
`timescale 1ns/1ps

module tb_regfile_sequencer;
  localparam int T  = 4;
  localparam int IW = 3;

  typedef struct packed {
    logic [3:0]    com;
    logic [IW-1:0] sel;
    logic          start;
    logic          done;
    logic          ready;
  } cyc_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          i_req_valid = 1'b0;
  logic          o_req_ready;
  logic [2:0]    i_req_kind = '0;
  logic [IW-1:0] i_req_a = '0;
  logic [IW-1:0] i_req_b = '0;
  logic [IW-1:0] i_req_c = '0;
  logic [3:0]    o_com;
  logic [IW-1:0] o_sel;
  logic          o_alu_start;
  logic          i_alu_done = 1'b0;
  logic          o_done;
  logic          o_err;
  logic          i_err_clr = 1'b0;

  int   checks = 0;
  int   errors = 0;
  logic err_model = 1'b0;
  cyc_t trace[$];

  regfile_sequencer #(.ALU_TIMEOUT(T), .INDEX_WIDTH(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_kind(i_req_kind), .i_req_a(i_req_a), .i_req_b(i_req_b), .i_req_c(i_req_c),
    .o_com(o_com), .o_sel(o_sel), .o_alu_start(o_alu_start),
    .i_alu_done(i_alu_done), .o_done(o_done), .o_err(o_err), .i_err_clr(i_err_clr)
  );

  always #5 clk = ~clk;

  function automatic cyc_t mk(input logic [3:0] com, input logic [IW-1:0] sel,
                              input logic st, input logic dn, input logic rd);
    cyc_t x;
    x.com = com; x.sel = sel; x.start = st; x.done = dn; x.ready = rd;
    return x;
  endfunction

  // Operation-level model: expected outputs for cycles 1..N after acceptance.
  // n = ALU done latency after start (0 = never).
  task automatic build(input int kind, input logic [IW-1:0] a, input logic [IW-1:0] b,
                       input logic [IW-1:0] c, input int n, output logic err);
    trace.delete();
    err = 1'b0;
    if (kind == 0) begin
      trace.push_back(mk(4'd4, a, 1'b0, 1'b0, 1'b0));
      trace.push_back(mk(4'd1, '0, 1'b0, 1'b0, 1'b0));
      if (b != a) trace.push_back(mk(4'd4, b, 1'b0, 1'b0, 1'b0));
      trace.push_back(mk(4'd2, '0, 1'b1, 1'b0, 1'b0));
      if (n >= 1 && n <= T - 1) begin
        repeat (n) trace.push_back(mk(4'd0, '0, 1'b0, 1'b0, 1'b0));
        if (c != b) trace.push_back(mk(4'd4, c, 1'b0, 1'b0, 1'b0));
        trace.push_back(mk(4'd3, '0, 1'b0, 1'b1, 1'b0));
      end else begin
        repeat (T - 1) trace.push_back(mk(4'd0, '0, 1'b0, 1'b0, 1'b0));
        trace.push_back(mk(4'd0, '0, 1'b0, 1'b1, 1'b1));
        err = 1'b1;
      end
    end else if (kind == 7) begin
      trace.push_back(mk(4'd0, '0, 1'b0, 1'b1, 1'b1));
      err = 1'b1;
    end else begin
      trace.push_back(mk(4'(4 + kind), '0, 1'b0, 1'b1, 1'b0));
    end
  endtask

  // Accepts one request at the next idle cycle and compares every cycle of it.
  task automatic run_op(input int kind, input logic [IW-1:0] a, input logic [IW-1:0] b,
                        input logic [IW-1:0] c, input int n, output int done_cyc);
    cyc_t got;
    logic e;
    int   s;
    build(kind, a, b, c, n, e);
    s = (b == a) ? 3 : 4;
    @(negedge clk);
    checks++;
    if (o_req_ready !== 1'b1 || o_com !== 4'd0 || o_done !== 1'b0) begin
      errors++;
      $display("FAIL idle_before_req: ready=%b com=%0d done=%b, required ready=1 com=0 done=0",
               o_req_ready, o_com, o_done);
    end
    i_req_valid = 1'b1;
    i_req_kind  = 3'(kind);
    i_req_a = a; i_req_b = b; i_req_c = c;
    i_alu_done = 1'($urandom % 2);
    done_cyc = -1;
    for (int k = 1; k <= trace.size(); k++) begin
      @(negedge clk);
      i_req_valid = 1'b0;
      i_req_kind  = 3'($urandom);
      i_req_a = IW'($urandom); i_req_b = IW'($urandom); i_req_c = IW'($urandom);
      if (kind == 0) begin
        if (k <= s)                        i_alu_done = 1'($urandom % 2);
        else if (n != 0 && k == s + n)     i_alu_done = 1'b1;
        else if (n != 0 && k > s + n)      i_alu_done = 1'($urandom % 2);
        else                               i_alu_done = 1'b0;
      end else begin
        i_alu_done = 1'($urandom % 2);
      end
      got = {o_com, o_sel, o_alu_start, o_done, o_req_ready};
      checks++;
      if (got !== trace[k-1]) begin
        errors++;
        $display("FAIL trace kind=%0d cyc=%0d: got com=%0d sel=%0d start=%b done=%b ready=%b, required com=%0d sel=%0d start=%b done=%b ready=%b",
                 kind, k, got.com, got.sel, got.start, got.done, got.ready,
                 trace[k-1].com, trace[k-1].sel, trace[k-1].start, trace[k-1].done, trace[k-1].ready);
      end
      if (o_done === 1'b1 && done_cyc < 0) done_cyc = k;
    end
    i_alu_done = 1'b0;
    if (e) err_model = 1'b1;
    checks++;
    if (o_err !== err_model) begin
      errors++;
      $display("FAIL err_after_op kind=%0d: o_err=%b, required %b", kind, o_err, err_model);
    end
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if ({o_com, o_sel, o_alu_start, o_done, o_err, o_req_ready} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: com=%0d sel=%0d start=%b done=%b err=%b ready=%b, required all 0",
               o_com, o_sel, o_alu_start, o_done, o_err, o_req_ready);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (o_req_ready !== 1'b1 || o_com !== 4'd0) begin
      errors++;
      $display("FAIL ready_after_reset: ready=%b com=%0d, required ready=1 com=0", o_req_ready, o_com);
    end
    err_model = 1'b0;
  endtask

  task automatic test_alu_directed;
    int dc;
    run_op(0, 3'd1, 3'd2, 3'd3, 2, dc);
    checks++;
    if (dc !== 8) begin errors++; $display("FAIL alu_123_done_cycle: got %0d, required 8", dc); end
    run_op(0, 3'd5, 3'd5, 3'd5, 1, dc);
    checks++;
    if (dc !== 5) begin errors++; $display("FAIL alu_555_done_cycle: got %0d, required 5", dc); end
  endtask

  task automatic test_timeout;
    int dc;
    run_op(0, 3'd1, 3'd2, 3'd3, 0, dc);
    checks++;
    if (dc !== 8) begin errors++; $display("FAIL timeout_done_cycle: got %0d, required 8", dc); end
    i_err_clr = 1'b1;
    @(negedge clk);
    i_err_clr = 1'b0;
    err_model = 1'b0;
    checks++;
    if (o_err !== 1'b0) begin errors++; $display("FAIL err_clr: o_err=%b, required 0", o_err); end
  endtask

  task automatic test_alu_boundaries;
    int dc;
    // done in the last wait cycle wins over the timeout
    run_op(0, 3'd0, 3'd4, 3'd6, T - 1, dc);
    checks++;
    if (dc !== 6 + T - 1) begin errors++; $display("FAIL done_at_limit: got %0d, required %0d", dc, 6 + T - 1); end
    // done one cycle too late is a timeout
    run_op(0, 3'd2, 3'd2, 3'd7, T, dc);
    checks++;
    if (dc !== 3 + T) begin errors++; $display("FAIL done_late: got %0d, required %0d", dc, 3 + T); end
    i_err_clr = 1'b1;
    @(negedge clk);
    i_err_clr = 1'b0;
    err_model = 1'b0;
  endtask

  task automatic test_back_to_back;
    int dc;
    run_op(1, 3'd0, 3'd0, 3'd0, 0, dc);
    checks++;
    if (dc !== 1) begin errors++; $display("FAIL readsp_done_cycle: got %0d, required 1", dc); end
    run_op(5, 3'd0, 3'd0, 3'd0, 0, dc);
    checks++;
    if (dc !== 1) begin errors++; $display("FAIL latchf_done_cycle: got %0d, required 1", dc); end
  endtask

  task automatic test_illegal;
    @(negedge clk);
    i_req_valid = 1'b1;
    i_req_kind  = 3'd7;
    i_err_clr   = 1'b1;
    @(negedge clk);
    i_err_clr  = 1'b0;
    i_req_kind = 3'd2;
    checks++;
    if (o_com !== 4'd0 || o_done !== 1'b1 || o_err !== 1'b1 || o_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL illegal_cycle1: com=%0d done=%b err=%b ready=%b, required com=0 done=1 err=1 ready=1",
               o_com, o_done, o_err, o_req_ready);
    end
    @(negedge clk);
    i_req_valid = 1'b0;
    checks++;
    if (o_com !== 4'd6 || o_done !== 1'b1 || o_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL accept_after_illegal: com=%0d done=%b ready=%b, required com=6 done=1 ready=0",
               o_com, o_done, o_req_ready);
    end
    i_err_clr = 1'b1;
    @(negedge clk);
    i_err_clr = 1'b0;
    err_model = 1'b0;
    checks++;
    if (o_err !== 1'b0) begin errors++; $display("FAIL illegal_err_clr: o_err=%b, required 0", o_err); end
  endtask

  task automatic test_reset_mid;
    logic saw_latchc;
    @(negedge clk);
    i_req_valid = 1'b1;
    i_req_kind = 3'd0; i_req_a = 3'd1; i_req_b = 3'd2; i_req_c = 3'd3;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      i_req_valid = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({o_com, o_sel, o_alu_start, o_done, o_err, o_req_ready} !== '0) begin
      errors++;
      $display("FAIL reset_in_wait: com=%0d sel=%0d start=%b done=%b err=%b ready=%b, required all 0",
               o_com, o_sel, o_alu_start, o_done, o_err, o_req_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    i_alu_done = 1'b1;
    saw_latchc = 1'b0;
    @(negedge clk);
    checks++;
    if (o_req_ready !== 1'b1) begin errors++; $display("FAIL ready_after_mid_reset: ready=%b, required 1", o_req_ready); end
    for (int k = 0; k < 10; k++) begin
      if (o_com === 4'd3) saw_latchc = 1'b1;
      @(negedge clk);
    end
    i_alu_done = 1'b0;
    checks++;
    if (saw_latchc !== 1'b0) begin errors++; $display("FAIL latchc_after_reset: seen=%b, required 0", saw_latchc); end
    err_model = 1'b0;
  endtask

  task automatic test_random;
    int kind, n, dc, exp_dc;
    logic [IW-1:0] a, b, c;
    for (int i = 0; i < 60; i++) begin
      kind = int'($urandom_range(0, 7));
      a = IW'($urandom); b = IW'($urandom); c = IW'($urandom);
      if ($urandom % 3 == 0) b = a;
      if ($urandom % 3 == 0) c = b;
      n = int'($urandom_range(0, T + 1));
      run_op(kind, a, b, c, n, dc);
      if (kind == 0 && n >= 1 && n <= T - 1) begin
        exp_dc = 6 + n - ((a == b) ? 1 : 0) - ((c == b) ? 1 : 0);
        checks++;
        if (dc !== exp_dc) begin
          errors++;
          $display("FAIL alu_latency a=%0d b=%0d c=%0d n=%0d: got %0d, required %0d", a, b, c, n, dc, exp_dc);
        end
      end
      if (err_model && ($urandom % 2 == 0)) begin
        i_err_clr = 1'b1;
        @(negedge clk);
        i_err_clr = 1'b0;
        err_model = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset;
    test_alu_directed;
    test_timeout;
    test_alu_boundaries;
    test_back_to_back;
    test_illegal;
    test_reset_mid;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
